q_sys_cali_apply: RTL and testbench

//  Per-channel gain correction between the fibre ADC sample stream and the DAQ packer.

---
 rtl/q_sys_cali_pkg.sv | 18 +
 rtl/q_sys_cali_if.sv | 50 +++++
 rtl/q_sys_cali_port_arb.sv | 94 +++++++++
 rtl/q_sys_cali_apply.sv | 121 ++++++++++++
 tb/tb_q_sys_cali_apply.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/q_sys_cali_pkg.sv
// Shared widths, unity gain and port-arbiter state encoding for the CALI gain-apply block.
package q_sys_cali_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 9;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 7;
  localparam int PROD_W    = DATA_W + GAIN_W;

  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'd128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STREAM   = 3'd1,
    HOST_WR  = 3'd2,
    HOST_RD  = 3'd3,
    HOST_RD2 = 3'd4
  } arb_state_t;
endpackage

// File: rtl/q_sys_cali_if.sv
// Bus bundle: sample stream in/out, host Avalon slave and the CALI RAM port.
interface q_sys_cali_if;
  import q_sys_cali_pkg::*;

  // Stream: a beat transfers on a cycle where valid & ready are both high;
  // valid and its payload are held stable until that cycle, ready may change freely.
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] s_chan;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_eof;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eof;
  logic              m_sat;

  logic [ADDR_W-1:0] h_address;
  logic              h_read;
  logic              h_write;
  logic [GAIN_W-1:0] h_writedata;
  logic [GAIN_W-1:0] h_readdata;
  logic              h_waitrequest;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [GAIN_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [GAIN_W-1:0] ram_readdata;

  modport slave (
    input  s_valid, s_chan, s_data, s_sof, s_eof, m_ready,
    input  h_address, h_read, h_write, h_writedata, ram_readdata,
    output s_ready, m_valid, m_data, m_sof, m_eof, m_sat,
    output h_readdata, h_waitrequest,
    output ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken
  );

  modport master (
    output s_valid, s_chan, s_data, s_sof, s_eof, m_ready,
    output h_address, h_read, h_write, h_writedata, ram_readdata,
    input  s_ready, m_valid, m_data, m_sof, m_eof, m_sat,
    input  h_readdata, h_waitrequest,
    input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken
  );
endinterface

// File: rtl/q_sys_cali_port_arb.sv
// Owns the single CALI port: arbitrates stream lookups against host Avalon access,
// letting the host in only while the stream is idle between frames.
module q_sys_cali_port_arb
  import q_sys_cali_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_fire,
  input  logic              i_drain_ok,
  input  logic [ADDR_W-1:0] i_s_chan,
  input  logic [ADDR_W-1:0] i_h_address,
  input  logic              i_h_read,
  input  logic              i_h_write,
  input  logic [GAIN_W-1:0] i_h_writedata,
  input  logic [GAIN_W-1:0] i_ram_readdata,
  output logic              o_s_ready,
  output logic [GAIN_W-1:0] o_h_readdata,
  output logic              o_h_waitrequest,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic              o_ram_chipselect,
  output logic              o_ram_write,
  output logic [GAIN_W-1:0] o_ram_writedata,
  output logic              o_ram_clken,
  output arb_state_t        o_state
);
  arb_state_t r_state;
  logic       r_host;
  logic       r_waitreq;
  logic       r_cs;
  logic       w_host_req;

  assign w_host_req = i_h_read | i_h_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_host    <= 1'b0;
      r_waitreq <= 1'b1;
      r_cs      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Write wins over read, and any host request wins over a waiting sample.
          if (i_h_write) begin
            r_state   <= HOST_WR;
            r_host    <= 1'b1;
            r_waitreq <= 1'b0;
            r_cs      <= 1'b1;
          end else if (i_h_read) begin
            r_state <= HOST_RD;
            r_host  <= 1'b1;
          end else if (i_fire) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (i_drain_ok) r_state <= IDLE;
        end
        HOST_WR: begin
          r_state   <= IDLE;
          r_host    <= 1'b0;
          r_waitreq <= 1'b1;
          r_cs      <= 1'b0;
        end
        HOST_RD: begin
          r_state   <= HOST_RD2;
          r_waitreq <= 1'b0;
        end
        HOST_RD2: begin
          r_state   <= IDLE;
          r_host    <= 1'b0;
          r_waitreq <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_host    <= 1'b0;
          r_waitreq <= 1'b1;
          r_cs      <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_ready        = ~reset & i_en & ~r_host & ~((r_state == IDLE) & w_host_req);
  assign o_ram_address    = r_host ? i_h_address : i_s_chan;
  assign o_ram_clken      = r_host | i_en;
  assign o_ram_chipselect = r_cs;
  assign o_ram_write      = r_cs;
  assign o_ram_writedata  = i_h_writedata;
  assign o_h_waitrequest  = r_waitreq;
  assign o_h_readdata     = (r_state == HOST_RD2) ? i_ram_readdata : '0;
  assign o_state          = r_state;
endmodule

// File: rtl/q_sys_cali_apply.sv
// Per-channel gain correction: 2-stage lookup/scale/saturate pipeline with frame
// tracking and saturation counter; CALI port arbitration lives in the sub-module.
module q_sys_cali_apply
  import q_sys_cali_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bypass,
  q_sys_cali_if.slave bus,
  output logic [15:0] sat_count,
  output logic        frame_err,
  output arb_state_t  o_dbg_state
);
  logic              w_en;
  logic              w_s_ready;
  logic              w_fire;
  logic              w_drain_ok;
  logic              w_ovf;
  logic [GAIN_W-1:0] w_gain;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_res;

  logic              r_s1_valid;
  logic              r_s1_sof;
  logic              r_s1_eof;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_m_valid;
  logic              r_m_sof;
  logic              r_m_eof;
  logic              r_m_sat;
  logic [DATA_W-1:0] r_m_data;
  logic              r_in_frame;
  logic              r_frame_err;
  logic [15:0]       r_sat_count;

  assign w_en       = ~r_m_valid | bus.m_ready;
  assign w_fire     = bus.s_valid & w_s_ready;
  assign w_drain_ok = ~r_in_frame & ~r_s1_valid & ~r_m_valid & ~w_fire;

  // Gain arrives from CALI one cycle after the address, lined up with stage 1.
  assign w_gain = bypass ? UNITY_GAIN : bus.ram_readdata;
  assign w_prod = PROD_W'(r_s1_data) * PROD_W'(w_gain);
  assign w_res  = w_prod >> GAIN_FRAC;
  assign w_ovf  = |w_res[PROD_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_s1_data  <= '0;
      r_m_valid  <= 1'b0;
      r_m_sof    <= 1'b0;
      r_m_eof    <= 1'b0;
      r_m_sat    <= 1'b0;
      r_m_data   <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_fire;
      r_s1_sof   <= w_fire & bus.s_sof;
      r_s1_eof   <= w_fire & bus.s_eof;
      r_s1_data  <= bus.s_data;
      r_m_valid  <= r_s1_valid;
      r_m_sof    <= r_s1_sof;
      r_m_eof    <= r_s1_eof;
      r_m_sat    <= r_s1_valid & w_ovf;
      r_m_data   <= w_ovf ? {DATA_W{1'b1}} : w_res[DATA_W-1:0];
    end
  end

  // A beat carrying both markers is a complete one-sample frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_frame  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_fire) begin
      if (bus.s_sof & r_in_frame) r_frame_err <= 1'b1;
      if (bus.s_eof)              r_in_frame  <= 1'b0;
      else if (bus.s_sof)         r_in_frame  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (r_m_valid & bus.m_ready & r_m_sat & (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  q_sys_cali_port_arb u_arb (
    .clk              (clk),
    .reset            (reset),
    .i_en             (w_en),
    .i_fire           (w_fire),
    .i_drain_ok       (w_drain_ok),
    .i_s_chan         (bus.s_chan),
    .i_h_address      (bus.h_address),
    .i_h_read         (bus.h_read),
    .i_h_write        (bus.h_write),
    .i_h_writedata    (bus.h_writedata),
    .i_ram_readdata   (bus.ram_readdata),
    .o_s_ready        (w_s_ready),
    .o_h_readdata     (bus.h_readdata),
    .o_h_waitrequest  (bus.h_waitrequest),
    .o_ram_address    (bus.ram_address),
    .o_ram_chipselect (bus.ram_chipselect),
    .o_ram_write      (bus.ram_write),
    .o_ram_writedata  (bus.ram_writedata),
    .o_ram_clken      (bus.ram_clken),
    .o_state          (o_dbg_state)
  );

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_sof   = r_m_sof;
  assign bus.m_eof   = r_m_eof;
  assign bus.m_sat   = r_m_sat;
  assign sat_count   = r_sat_count;
  assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_q_sys_cali_apply.sv
// Directed bench for q_sys_cali_apply with a CALI RAM model and an output scoreboard.
module tb_q_sys_cali_apply;
  import q_sys_cali_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bypass = 1'b0;
  logic [15:0] sat_count;
  logic        frame_err;
  arb_state_t  dbg_state;

  q_sys_cali_if bus();

  q_sys_cali_apply dut (
    .clk         (clk),
    .reset       (reset),
    .bypass      (bypass),
    .bus         (bus.slave),
    .sat_count   (sat_count),
    .frame_err   (frame_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- CALI RAM model: registered address, unregistered q ----------------
  logic [7:0] mem [512] = '{default: 8'h00};
  logic [8:0] ram_aq = '0;
  always @(posedge clk) begin
    if (bus.ram_clken) begin
      if (bus.ram_chipselect && bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
      ram_aq <= bus.ram_address;
    end
  end
  assign bus.ram_readdata = mem[ram_aq];

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_out_cyc = 0;
  int          n_out = 0;
  logic [18:0] exp_q[$];
  int          cyc_q[$];
  logic [15:0] exp_sat_cnt = '0;
  logic [7:0]  cali_sh [512] = '{default: 8'h00};
  logic [18:0] mon_e;
  int          mon_lc;

  always @(posedge clk) cyc <= cyc + 1;

  // m_ready driver: fixed level, or the 1,0,0 pattern when tog_en is set
  bit tog_en = 1'b0;
  bit ready_fixed = 1'b1;
  int tog_k = 0;
  always @(posedge clk) begin
    #2;
    bus.m_ready = tog_en ? (tog_k % 3 == 0) : ready_fixed;
    tog_k++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic [15:0] d, input logic [7:0] g,
                                        input logic byp, input logic sof, input logic eof);
    logic [23:0] p;
    logic [16:0] r;
    p = 24'(d) * 24'(byp ? 8'd128 : g);
    r = p[23:7];
    if (r > 17'h0FFFF) return {sof, eof, 1'b1, 16'hFFFF};
    return {sof, eof, 1'b0, r[15:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed output %0h expected none", bus.m_data);
      end
      if (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_lc = cyc_q.pop_front();
        chk("m_data", 32'(bus.m_data), 32'(mon_e[15:0]));
        chk("m_sat", 32'(bus.m_sat), 32'(mon_e[16]));
        chk("m_eof", 32'(bus.m_eof), 32'(mon_e[17]));
        chk("m_sof", 32'(bus.m_sof), 32'(mon_e[18]));
        if (mon_lc >= 0) chk("latency", cyc, mon_lc);
        if (mon_e[16] && exp_sat_cnt != 16'hFFFF) exp_sat_cnt++;
        last_out_cyc = cyc;
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [8:0] ch, input logic [15:0] d, input logic sof,
                      input logic eof, input logic [15:0] ed, input logic es, input bit lat);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_chan  = ch;
    bus.s_data  = d;
    bus.s_sof   = sof;
    bus.s_eof   = eof;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("s_accept", 32'(ok), 32'd1);
    if (ok) begin
      exp_q.push_back({sof, eof, es, ed});
      cyc_q.push_back(lat ? cyc + 2 : -1);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_eof   = 1'b0;
  endtask

  task automatic send_m(input logic [8:0] ch, input logic [15:0] d, input logic sof, input logic eof);
    logic [18:0] e;
    e = model(d, cali_sh[ch], bypass, sof, eof);
    send(ch, d, sof, eof, e[15:0], e[16], 1'b0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d, output int waits, output int done_cyc);
    bit ok;
    ok = 1'b0;
    waits = 0;
    bus.h_address   = a;
    bus.h_writedata = d;
    bus.h_write     = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.h_waitrequest === 1'b0) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    done_cyc = cyc;
    chk("hw_done", 32'(ok), 32'd1);
    if (ok) cali_sh[a] = d;
    @(posedge clk);
    #1;
    bus.h_write = 1'b0;
    chk("hw_wreq_back", 32'(bus.h_waitrequest), 32'd1);
  endtask

  task automatic host_read(input logic [8:0] a, output logic [7:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    d = '0;
    bus.h_address = a;
    bus.h_read    = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.h_waitrequest === 1'b0) begin
        ok = 1'b1;
        d = bus.h_readdata;
        break;
      end
      waits++;
    end
    chk("hr_done", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.h_read = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int         hw_waits;
  int         hw_done;
  int         hr_waits;
  int         out_base;
  logic [7:0] rd;

  initial begin
    bus.s_valid     = 1'b0;
    bus.s_chan      = '0;
    bus.s_data      = '0;
    bus.s_sof       = 1'b0;
    bus.s_eof       = 1'b0;
    bus.h_address   = '0;
    bus.h_read      = 1'b0;
    bus.h_write     = 1'b0;
    bus.h_writedata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_sat", 32'(bus.m_sat), 32'd0);
    chk("rst_m_sof_eof", 32'({bus.m_sof, bus.m_eof}), 32'd0);
    chk("rst_wreq", 32'(bus.h_waitrequest), 32'd1);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // CALI setup through the host port
    host_write(9'd5, 8'd128, hw_waits, hw_done);
    chk("hw_idle_waits", hw_waits, 1);
    host_write(9'd6, 8'd64, hw_waits, hw_done);
    host_write(9'd7, 8'd255, hw_waits, hw_done);
    host_write(9'd8, 8'd0, hw_waits, hw_done);

    // unity and half gain, back to back, latency 2
    send(9'd5, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1);
    send(9'd6, 16'h1234, 1'b0, 1'b0, 16'h091A, 1'b0, 1'b1);
    drain();

    // saturation and zero gain
    send(9'd7, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    send(9'd8, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    drain();
    chk("sat_count_1", 32'(sat_count), 32'd1);
    chk("sat_count_model", 32'(sat_count), 32'(exp_sat_cnt));

    // back-pressure 1,0,0 pattern
    out_base = n_out;
    tog_en = 1'b1;
    for (int k = 0; k < 10; k++) send_m(9'd5, 16'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0);
    drain();
    tog_en = 1'b0;
    chk("bp_out_count", n_out - out_base, 10);

    // host write issued mid-frame must wait for the frame to drain
    send_m(9'd5, 16'h0100, 1'b1, 1'b0);
    fork
      host_write(9'd3, 8'h55, hw_waits, hw_done);
      begin
        for (int k = 0; k < 3; k++) begin
          send_m(9'd5, 16'h0200 + 16'(k), 1'b0, (k == 2));
          chk("wreq_midframe", 32'(bus.h_waitrequest), 32'd1);
        end
      end
    join
    drain();
    chk("host_after_drain", 32'(hw_done > last_out_cyc), 32'd1);
    host_read(9'd3, rd, hr_waits);
    chk("hr_data", 32'(rd), 32'h55);
    chk("hr_waits", hr_waits, 2);
    send(9'd3, 16'h0100, 1'b0, 1'b0, 16'h00AA, 1'b0, 1'b1);
    drain();
    chk("frame_err_clean", 32'(frame_err), 32'd0);

    // double sof, then a one-sample frame
    send_m(9'd5, 16'h0111, 1'b1, 1'b0);
    send_m(9'd5, 16'h0222, 1'b1, 1'b0);
    send_m(9'd6, 16'h0333, 1'b0, 1'b1);
    send_m(9'd5, 16'h0444, 1'b1, 1'b1);
    drain();
    chk("frame_err_set", 32'(frame_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("state_back_idle", 32'(dbg_state), 32'(IDLE));

    // bypass with zero gain passes data through
    bypass = 1'b1;
    send(9'd9, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1);
    drain();
    bypass = 1'b0;

    // reset while stalled
    ready_fixed = 1'b0;
    send(9'd6, 16'h0100, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0);
    send(9'd6, 16'h0200, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
    chk("stall_m_data", 32'(bus.m_data), 32'h0080);
    chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    exp_sat_cnt = '0;
    chk("rst2_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst2_wreq", 32'(bus.h_waitrequest), 32'd1);
    chk("rst2_sat_count", 32'(sat_count), 32'd0);
    chk("rst2_frame_err", 32'(frame_err), 32'd0);
    chk("rst2_state", 32'(dbg_state), 32'(IDLE));
    ready_fixed = 1'b1;
    send(9'd6, 16'h0100, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
